// File: rtl/vg_vmem_pkg.sv
// Shared types and defaults for the vector-memory arbiter.
// Optional build macro used by the arbiter: VMEM_ROM_PROTECT_EN.
package vg_vmem_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;
  localparam int BURST_W    = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VG   = 2'd2
  } tag_e;

endpackage

// File: rtl/vg_vmem_rd_pipe.sv
// Read-return pipe: tags each issued access, captures ram_rdata two cycles
// after issue and steers it to the requester that owns it.
module vg_vmem_rd_pipe
  import vg_vmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        tag_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] vg_rdata,
  output logic              vg_rvalid
);

  logic [1:0] tag_p0;
  logic [1:0] tag_p1;

  // p0: tag of the access driving ram_* this cycle; p1: RAM data arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_p0 <= TAG_NONE;
      tag_p1 <= TAG_NONE;
    end else begin
      tag_p0 <= tag_in;
      tag_p1 <= tag_p0;
    end
  end

  // p2: capture and steer; only one tag per slot, so one rvalid per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      vg_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      vg_rdata   <= '0;
    end else begin
      cpu_rvalid <= (tag_p1 == TAG_CPU);
      vg_rvalid  <= (tag_p1 == TAG_VG);
      if (tag_p1 == TAG_CPU) cpu_rdata <= ram_rdata;
      if (tag_p1 == TAG_VG)  vg_rdata  <= ram_rdata;
    end
  end

endmodule

// File: rtl/vg_vmem_arb.sv
// VMEM arbiter between the 6502 and the vector-generator fetch path.
// Build macro VMEM_ROM_PROTECT_EN drops CPU writes at or above ROM_BASE.
module vg_vmem_arb
  import vg_vmem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int VG_BURST_MAX = 4
`ifdef VMEM_ROM_PROTECT_EN
  , parameter logic [ADDR_W-1:0] ROM_BASE = 13'h1000
`endif
) (
  input  logic              clk_12MHz,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_r_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ovf,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vg_req,
  input  logic [ADDR_W-1:0] vg_addr,
  output logic              vg_gnt,
  output logic [DATA_W-1:0] vg_rdata,
  output logic              vg_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wp_err
);

  logic              busy_r;
  logic              ovf_r;
  logic              slot_rw;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;
  logic [BURST_W-1:0] burst_cnt;
  logic              cpu_grant;
  logic              vg_grant;
  logic              wp_hit;
  tag_e              tag_issue;

  assign cpu_busy = busy_r;
  assign cpu_ovf  = ovf_r;
  assign vg_gnt   = vg_grant;

  // The CPU only wins against a live VG request once the burst budget is spent
  always_comb begin
    cpu_grant = 1'b0;
    vg_grant  = 1'b0;
    if (!RESET) begin
      if (busy_r && (!vg_req || burst_cnt == BURST_W'(VG_BURST_MAX)))
        cpu_grant = 1'b1;
      else if (vg_req)
        vg_grant = 1'b1;
    end
  end

`ifdef VMEM_ROM_PROTECT_EN
  assign wp_hit = cpu_grant && !slot_rw && (slot_addr >= ROM_BASE);
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    tag_issue = TAG_NONE;
    if (cpu_grant && slot_rw) tag_issue = TAG_CPU;
    else if (vg_grant)        tag_issue = TAG_VG;
  end

  always_ff @(posedge clk_12MHz) begin
    if (RESET) begin
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (cpu_req && busy_r) ovf_r <= 1'b1;
      if (cpu_req && !busy_r) busy_r <= 1'b1;
      else if (cpu_grant)     busy_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (cpu_req && !busy_r) begin
      slot_rw    <= cpu_r_w;
      slot_addr  <= cpu_addr;
      slot_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (RESET || !busy_r || cpu_grant)
      burst_cnt <= '0;
    else if (vg_grant && burst_cnt != {BURST_W{1'b1}})
      burst_cnt <= burst_cnt + 1'b1;
  end

  // Issue stage: the grant of cycle t drives the RAM during t+1
  always_ff @(posedge clk_12MHz) begin
    if (RESET) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= (cpu_grant && !wp_hit) || vg_grant;
      ram_we <= cpu_grant && !slot_rw && !wp_hit;
      if (cpu_grant) begin
        ram_addr  <= slot_addr;
        ram_wdata <= slot_wdata;
      end else if (vg_grant) begin
        ram_addr  <= vg_addr;
      end
    end
  end

`ifdef VMEM_ROM_PROTECT_EN
  always_ff @(posedge clk_12MHz) begin
    if (RESET) wp_err <= 1'b0;
    else       wp_err <= wp_hit;
  end
`else
  assign wp_err = wp_hit;
`endif

  vg_vmem_rd_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk        (clk_12MHz),
    .rst        (RESET),
    .tag_in     (tag_issue),
    .ram_rdata  (ram_rdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .vg_rdata   (vg_rdata),
    .vg_rvalid  (vg_rvalid)
  );

endmodule

// File: tb/tb_vg_vmem_arb.sv
// Directed bench for vg_vmem_arb with a 1-cycle-latency RAM model.
// Build with VMEM_ROM_PROTECT_EN defined to cover the write-protect path.
module tb_vg_vmem_arb;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk_12MHz = 1'b0;
  logic          RESET;
  logic          cpu_req, cpu_r_w;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy, cpu_ovf, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vg_req, vg_gnt, vg_rvalid;
  logic [AW-1:0] vg_addr;
  logic [DW-1:0] vg_rdata;
  logic          ram_en, ram_we, wp_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_init;
  int            passed = 0;
  int            total  = 0;
  int            n;

  always #5 clk_12MHz = ~clk_12MHz;

  vg_vmem_arb dut (
    .clk_12MHz (clk_12MHz), .RESET (RESET),
    .cpu_req (cpu_req), .cpu_r_w (cpu_r_w), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_busy (cpu_busy), .cpu_ovf (cpu_ovf), .cpu_rdata (cpu_rdata), .cpu_rvalid (cpu_rvalid),
    .vg_req (vg_req), .vg_addr (vg_addr), .vg_gnt (vg_gnt),
    .vg_rdata (vg_rdata), .vg_rvalid (vg_rvalid),
    .ram_en (ram_en), .ram_we (ram_we), .ram_addr (ram_addr), .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata), .wp_err (wp_err)
  );

  function automatic logic [7:0] init_val(input int a);
    logic [31:0] av;
    av = a;
    if (a == 32'h0123) return 8'h5A;
    return av[7:0] ^ 8'hC3;
  endfunction

  always @(posedge clk_12MHz) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_12MHz);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_r_w = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    vg_req = 1'b0; vg_addr = '0;
    step(); mem_init = 1'b0; step();
    chk("rst_busy", cpu_busy, 0);   chk("rst_ovf", cpu_ovf, 0);
    chk("rst_ram_en", ram_en, 0);   chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rvalid", {cpu_rvalid, vg_rvalid}, 0);
    chk("rst_gnt", vg_gnt, 0);      chk("rst_wp", wp_err, 0);
    RESET = 1'b0; step();

    // CPU read alone
    cpu_req = 1'b1; cpu_r_w = 1'b1; cpu_addr = 13'h0123; #1;
    chk("t1_no_same_cycle_gnt", {cpu_busy, ram_en}, 0);
    step(); cpu_req = 1'b0;
    chk("t1_busy", cpu_busy, 1);
    step();
    chk("t1_ram_en", ram_en, 1); chk("t1_ram_we", ram_we, 0);
    chk("t1_ram_addr", ram_addr, 13'h0123); chk("t1_busy_clr", cpu_busy, 0);
    step(); chk("t1_rvalid_early", cpu_rvalid, 0);
    step(); chk("t1_rvalid", cpu_rvalid, 1); chk("t1_rdata", cpu_rdata, 8'h5A);
    step(); chk("t1_rvalid_pulse", cpu_rvalid, 0);

    // VG stream with a pending CPU write: 4 VG grants, then CPU
    vg_req = 1'b1; vg_addr = 13'h0040;
    cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 13'h0200; cpu_wdata = 8'h77; #1;
    chk("t2_vg_first", vg_gnt, 1);
    step(); cpu_req = 1'b0; #1;
    n = 0;
    while (cpu_busy && vg_gnt && n < 20) begin n++; step(); end
    chk("t2_burst_len", n, 4);
    chk("t2_cpu_wins", {cpu_busy, vg_gnt}, 2'b10);
    step();
    chk("t2_ram_we", {ram_en, ram_we}, 2'b11);
    chk("t2_ram_addr", ram_addr, 13'h0200); chk("t2_ram_wdata", ram_wdata, 8'h77);
    chk("t2_vg_resume", vg_gnt, 1); chk("t2_burst_cnt", dut.burst_cnt, 0);
    vg_req = 1'b0;
    repeat (5) step();
    chk("t2_mem", mem[13'h0200], 8'h77);

    // Back-to-back VG reads 0..7
    for (int c = 0; c < 12; c++) begin
      vg_req = (c < 8); vg_addr = AW'(c); #1;
      chk($sformatf("t3_gnt%0d", c), vg_gnt, (c < 8));
      chk($sformatf("t3_rv%0d", c), vg_rvalid, (c >= 3 && c < 11));
      if (c >= 3 && c < 11) chk($sformatf("t3_rd%0d", c), vg_rdata, init_val(c - 3));
      step();
    end
    vg_req = 1'b0;

    // Second cpu_req while busy is dropped
    cpu_req = 1'b1; cpu_r_w = 1'b1; cpu_addr = 13'h0123;
    step();
    cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 13'h0005; cpu_wdata = 8'hEE;
    vg_req = 1'b1; vg_addr = 13'h0010; #1;
    chk("t4_vg_gnt", vg_gnt, 1);
    step(); cpu_req = 1'b0; vg_req = 1'b0; #1;
    chk("t4_ovf", cpu_ovf, 1); chk("t4_busy", cpu_busy, 1);
    step();
    chk("t4_ram_addr", ram_addr, 13'h0123); chk("t4_ram_en_we", {ram_en, ram_we}, 2'b10);
    step();
    chk("t4_vg_rv", vg_rvalid, 1); chk("t4_vg_rd", vg_rdata, init_val(13'h0010));
    step();
    chk("t4_cpu_rv", {cpu_rvalid, vg_rvalid}, 2'b10); chk("t4_cpu_rd", cpu_rdata, 8'h5A);
    step();
    chk("t4_ovf_sticky", cpu_ovf, 1); chk("t4_busy_idle", cpu_busy, 0);
    chk("t4_no_write", mem[13'h0005], init_val(13'h0005));
    RESET = 1'b1; step(); RESET = 1'b0;
    chk("t4_ovf_rst", cpu_ovf, 0);
    step();

    // RESET one cycle after a VG grant, with a simultaneous cpu_req
    vg_req = 1'b1; vg_addr = 13'h0007; #1;
    chk("t5_gnt", vg_gnt, 1);
    step();
    vg_req = 1'b0; RESET = 1'b1; cpu_req = 1'b1; cpu_r_w = 1'b1; cpu_addr = 13'h0123; #1;
    chk("t5_issued", ram_en, 1);
    step(); RESET = 1'b0; cpu_req = 1'b0;
    chk("t5_outs_zero", {ram_en, ram_we, cpu_busy, cpu_ovf, cpu_rvalid, vg_rvalid, vg_gnt, wp_err}, 0);
    chk("t5_addr_zero", ram_addr, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("t5_no_rv%0d", c), {cpu_rvalid, vg_rvalid, cpu_busy}, 0);
    end

`ifdef VMEM_ROM_PROTECT_EN
    cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 13'h1004; cpu_wdata = 8'hFF;
    step(); cpu_req = 1'b0;
    chk("t6_busy", cpu_busy, 1);
    step();
    chk("t6_blocked", {ram_en, ram_we, wp_err, cpu_busy}, 4'b0010);
    cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 13'h0004; cpu_wdata = 8'h11;
    step(); cpu_req = 1'b0;
    chk("t6_wp_pulse", wp_err, 0);
    step();
    chk("t6_ok_write", {ram_en, ram_we, wp_err}, 3'b110); chk("t6_ok_addr", ram_addr, 13'h0004);
    step();
    chk("t6_rom_kept", mem[13'h1004], init_val(13'h1004)); chk("t6_ram_written", mem[13'h0004], 8'h11);
`else
    cpu_req = 1'b1; cpu_r_w = 1'b0; cpu_addr = 13'h1004; cpu_wdata = 8'hFF;
    step(); cpu_req = 1'b0;
    step();
    chk("t6_write_hi", {ram_en, ram_we, wp_err}, 3'b110); chk("t6_addr_hi", ram_addr, 13'h1004);
    step();
    chk("t6_mem_hi", mem[13'h1004], 8'hFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
